weights_load_sequencer: RTL and testbench
=========================================

Name: weights_load_sequencer

Overview:
- Controller that sequences one weights-buffer load/stream transaction for the systolic array.
- Reads an N×N weight tile from weight SRAM and writes it into the weights buffer through `input_data`/`writing_signal`.
- Waits for the buffer's `data_ready`, then drives `inputs_data_ready` to stream the 2N-1 skewed columns into the array, honouring array back-pressure.
- Emits a column-valid/index sideband, then a done pulse.

Parameters:
- MATRIX_SIZE, 2, N: array/tile dimension; the tile holds N*N words.
- DATA_WIDTH, 16, weight word width (signed, passed through unmodified).
- ADDR_WIDTH, 12, weight SRAM address width.
- READY_TIMEOUT, 64, maximum cycles spent in WAIT_READY before aborting.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  SRAM address of tile word 0; captured with start.
- busy  out  1  high from the cycle after start is accepted through the done/err cycle.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on ready timeout.
- mem_rd_en  out  1  SRAM read strobe; data returns exactly 1 cycle later.
- mem_addr  out  ADDR_WIDTH  SRAM read address.
- mem_rd_data  in  DATA_WIDTH  SRAM read data.
- wgt_data  out  DATA_WIDTH  to buffer `input_data`; combinational copy of mem_rd_data.
- wgt_write  out  1  to buffer `writing_signal`.
- buf_data_ready  in  1  from buffer `data_ready`.
- buf_stream  out  1  to buffer `inputs_data_ready`.
- array_stall  in  1  array back-pressure; holds streaming while high.
- col_valid  out  1  high while the buffer's column output holds a valid column.
- col_index  out  8  index of the current column, 0..2N-2.

Behaviour:
- Reset (asynchronous, any state): go to IDLE. All outputs 0: busy, done, err, mem_rd_en, mem_addr, wgt_write, buf_stream, col_valid, col_index. All counters cleared. Reset mid-transaction abandons it; the buffer is reset by the same rstn.
- States: IDLE, LOAD, DRAIN, WAIT_READY, STREAM, FLUSH, FINISH.
- IDLE:
  - start=1 at cycle T: capture base_addr, go to LOAD at T+1.
  - start outside IDLE is ignored; it is not queued.
- LOAD: mem_rd_en=1 for exactly N*N consecutive cycles, mem_addr = base_addr+k for k=0..N*N-1, wrapping modulo 2^ADDR_WIDTH. After the last read, go to DRAIN.
- Write timing: wgt_write is mem_rd_en registered once. wgt_data is mem_rd_data. This gives exactly N*N buffer writes, in SRAM order.
- DRAIN: one cycle, covering the final write. Then go to WAIT_READY.
- WAIT_READY:
  - Wait for buf_data_ready=1; then go to STREAM.
  - A timeout counter increments every WAIT_READY cycle. On reaching READY_TIMEOUT: err pulse, go to IDLE.
- STREAM:
  - buf_stream = !array_stall (combinational from state and stall).
  - Each cycle with buf_stream=1 emits column s, for s=0..2N-2.
  - The following cycle has col_valid=1 and col_index=s, matching the buffer's registered output.
  - When no column is emitted (stall), col_valid=0 the next cycle.
  - After 2N-1 emitted columns, go to FLUSH.
- FLUSH:
  - buf_stream = !array_stall. The buffer's clear cycle occurs on the first unstalled FLUSH cycle.
  - That cycle produces no col_valid. Then go to FINISH.
- FINISH: done=1 and busy=1 for one cycle, then IDLE with busy=0. A new start is accepted in the cycle after FINISH.
- Counter widths: load counter ≥ clog2(N*N+1); stream counter ≥ clog2(2N).
- Outputs other than wgt_data and buf_stream are registered.

Test Plan:
- N=2, start at T with base_addr=0x010, SRAM[0x010..0x013]=1,2,3,4, no stall:
  - mem_rd_en at T+1..T+4, addresses 0x010..0x013.
  - wgt_write at T+2..T+5 with data 1,2,3,4.
  - buf_stream high 4 cycles.
  - col_valid high 3 cycles, col_index 0,1,2; columns equal to (1,0),(3,2),(0,4).
  - done 1 cycle, busy falls the next cycle.
- Stall: array_stall=1 on the 2nd STREAM cycle for 3 cycles:
  - buf_stream low those 3 cycles.
  - col_index sequence still 0,1,2 with no gaps in order and no duplicates.
  - Exactly 3 col_valid cycles total.
- Address wrap: ADDR_WIDTH=12, base_addr=0xFFE -> addresses 0xFFE, 0xFFF, 0x000, 0x001.
- start pulsed during LOAD and STREAM -> ignored; exactly one done; a second start the cycle after done runs a full second transaction.
- buf_data_ready tied 0 after load -> err pulse after 64 WAIT_READY cycles, busy 0, no buf_stream.
- rstn asserted at the 3rd LOAD cycle -> all outputs 0 immediately (asynchronously); a restarted transaction completes correctly.

Source files
------------

// File: rtl/weights_load_sequencer.sv
// Sequences one weight-tile transaction: SRAM -> weights buffer load, wait for the
// buffer to become ready, stream the 2N-1 skewed columns into the array, then report done.
module weights_load_sequencer #(
  parameter int MATRIX_SIZE   = 2,
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 12,
  parameter int READY_TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] wgt_data,
  output logic                  wgt_write,
  input  logic                  buf_data_ready,
  output logic                  buf_stream,
  input  logic                  array_stall,
  output logic                  col_valid,
  output logic [7:0]            col_index
);

  localparam int N     = MATRIX_SIZE;
  localparam int WORDS = N * N;
  localparam int COLS  = 2 * N - 1;
  localparam int LCW   = $clog2(WORDS + 1);
  localparam int SCW   = $clog2(2 * N);
  localparam int TCW   = $clog2(READY_TIMEOUT + 1);

  localparam logic [LCW-1:0] LOAD_LAST = LCW'(WORDS - 1);
  localparam logic [SCW-1:0] COL_LAST  = SCW'(COLS - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(READY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, DRAIN, WAIT_READY, STREAM, FLUSH, FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [LCW-1:0]        load_cnt_q, load_cnt_d;
  logic [SCW-1:0]        strm_cnt_q, strm_cnt_d;
  logic [TCW-1:0]        tmo_cnt_q, tmo_cnt_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rd_en_q, rd_en_d;
  logic                  wr_q, wr_d;
  logic                  col_valid_q, col_valid_d;
  logic [7:0]            col_index_q, col_index_d;

  assign buf_stream = ((state_q == STREAM) || (state_q == FLUSH)) && !array_stall;
  assign wgt_data   = mem_rd_data;

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = mem_addr_q;
  assign wgt_write = wr_q;
  assign col_valid = col_valid_q;
  assign col_index = col_index_q;

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    strm_cnt_d  = strm_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    mem_addr_d  = mem_addr_q;
    col_index_d = col_index_q;
    col_valid_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mem_addr_d = base_addr;
          load_cnt_d = '0;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
        load_cnt_d = load_cnt_q + LCW'(1);
        if (load_cnt_q == LOAD_LAST) state_d = DRAIN;
      end
      DRAIN: begin
        tmo_cnt_d = '0;
        state_d   = WAIT_READY;
      end
      WAIT_READY: begin
        if (buf_data_ready) begin
          strm_cnt_d = '0;
          state_d    = STREAM;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TCW'(1);
        end
      end
      STREAM: begin
        // The column leaves the buffer only on an unstalled cycle, so the index advances with it.
        if (!array_stall) begin
          col_valid_d = 1'b1;
          col_index_d = 8'(strm_cnt_q);
          strm_cnt_d  = strm_cnt_q + SCW'(1);
          if (strm_cnt_q == COL_LAST) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!array_stall) state_d = FINISH;
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_en_d = (state_d == LOAD);
    wr_d    = rd_en_q;
    done_d  = (state_d == FINISH);
    // An error cycle still counts as busy even though the FSM is already back in IDLE.
    busy_d  = (state_d != IDLE) || err_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      load_cnt_q  <= '0;
      strm_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_q        <= 1'b0;
      col_valid_q <= 1'b0;
      col_index_q <= '0;
    end else begin
      state_q     <= state_d;
      load_cnt_q  <= load_cnt_d;
      strm_cnt_q  <= strm_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_en_q     <= rd_en_d;
      wr_q        <= wr_d;
      col_valid_q <= col_valid_d;
      col_index_q <= col_index_d;
    end
  end

endmodule

// File: tb/tb_weights_load_sequencer.sv
// Scoreboard bench for weights_load_sequencer: expected reads, writes and column
// indices are queued per transaction and popped by a negedge monitor.
module tb_weights_load_sequencer;

  localparam int N   = 2;
  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          busy, done, err, mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic [DW-1:0] wgt_data;
  logic          wgt_write;
  logic          buf_data_ready;
  logic          buf_stream;
  logic          array_stall;
  logic          col_valid;
  logic [7:0]    col_index;

  int vectors = 0;
  int miscompares = 0;
  int col_valid_cnt = 0;
  int done_cnt = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_data_q[$];
  int            exp_col_q[$];

  logic [DW-1:0] sram [0:4095];

  always #5 clk = ~clk;

  weights_load_sequencer #(
    .MATRIX_SIZE(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READY_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .err(err),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .wgt_data(wgt_data), .wgt_write(wgt_write),
    .buf_data_ready(buf_data_ready), .buf_stream(buf_stream),
    .array_stall(array_stall),
    .col_valid(col_valid), .col_index(col_index)
  );

  // Weight SRAM model: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= sram[mem_addr];
  end

  // Scoreboard monitor: every strobe must match the head of its expectation queue.
  always @(negedge clk) begin : monitor
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            ec;
    if (rstn) begin
      if (mem_rd_en) begin
        vectors++;
        if (exp_addr_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL rd_addr: unexpected read at 0x%03h, none required", mem_addr);
        end else begin
          ea = exp_addr_q.pop_front();
          if (mem_addr !== ea) begin
            miscompares++;
            $display("[TB] FAIL rd_addr: got 0x%03h, required 0x%03h", mem_addr, ea);
          end
        end
      end
      if (wgt_write) begin
        vectors++;
        if (exp_data_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL wr_data: unexpected write of 0x%04h, none required", wgt_data);
        end else begin
          ed = exp_data_q.pop_front();
          if (wgt_data !== ed) begin
            miscompares++;
            $display("[TB] FAIL wr_data: got 0x%04h, required 0x%04h", wgt_data, ed);
          end
        end
      end
      if (col_valid) begin
        col_valid_cnt++;
        vectors++;
        if (exp_col_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL col_index: unexpected column %0d, none required", col_index);
        end else begin
          ec = exp_col_q.pop_front();
          if (int'(col_index) !== ec) begin
            miscompares++;
            $display("[TB] FAIL col_index: got %0d, required %0d", col_index, ec);
          end
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_txn(input logic [AW-1:0] base, input bit with_cols);
    logic [AW-1:0] a;
    for (int k = 0; k < N * N; k++) begin
      a = base + AW'(k);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(sram[a]);
    end
    if (with_cols) for (int s = 0; s < 2 * N - 1; s++) exp_col_q.push_back(s);
  endtask

  task automatic issue_start(input logic [AW-1:0] base);
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL %s_done: done not seen within %0d cycles, required a pulse", name, budget);
    end
  endtask

  task automatic check_queues_empty(input string name);
    vectors++;
    if (exp_addr_q.size() != 0 || exp_data_q.size() != 0 || exp_col_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: leftover addr=%0d data=%0d col=%0d, required 0/0/0",
               name, exp_addr_q.size(), exp_data_q.size(), exp_col_q.size());
    end
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_col_q.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    #1;
    vectors++;
    if ({busy, done, err, mem_rd_en, mem_addr, wgt_write, buf_stream, col_valid, col_index} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b, required all zero",
               {busy, done, err, mem_rd_en, mem_addr, wgt_write, buf_stream, col_valid, col_index});
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Cycle-exact timeline from the first LOAD cycle (k=0) with ready high and no stall.
  task automatic test_basic();
    logic [5:0] got, want;
    push_txn(12'h010, 1'b1);
    issue_start(12'h010);
    for (int k = 0; k < 12; k++) begin
      got  = {busy, mem_rd_en, wgt_write, buf_stream, col_valid, done};
      want = {k <= 10, k <= 3, (k >= 1 && k <= 4), (k >= 6 && k <= 9), (k >= 7 && k <= 9), k == 10};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL basic_cycle%0d: {busy,rd,wr,strm,cv,done} got %b, required %b", k, got, want);
      end
      @(negedge clk);
    end
    check_queues_empty("basic");
  endtask

  task automatic test_stall();
    bit seen = 1'b0;
    col_valid_cnt = 0;
    push_txn(12'h020, 1'b1);
    issue_start(12'h020);
    for (int i = 0; i < 40 && !seen; i++) begin
      if (buf_stream) seen = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL stall_stream_start: buf_stream never rose, required 1");
    end
    @(negedge clk);
    array_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (buf_stream !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL stall_buf_stream%0d: got %b, required 0", i, buf_stream);
      end
      @(negedge clk);
    end
    array_stall = 1'b0;
    wait_done("stall", 40);
    @(negedge clk);
    vectors++;
    if (col_valid_cnt != 3) begin
      miscompares++;
      $display("[TB] FAIL stall_col_count: got %0d, required 3", col_valid_cnt);
    end
    check_queues_empty("stall");
  endtask

  task automatic test_wrap();
    push_txn(12'hFFE, 1'b1);
    issue_start(12'hFFE);
    wait_done("wrap", 40);
    @(negedge clk);
    check_queues_empty("wrap");
  endtask

  task automatic test_back_to_back();
    bit seen = 1'b0;
    done_cnt = 0;
    push_txn(12'h030, 1'b1);
    issue_start(12'h030);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (buf_stream) seen = 1'b1;
      else @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_first", 40);
    push_txn(12'h040, 1'b1);
    issue_start(12'h040);
    wait_done("b2b_second", 40);
    repeat (10) @(negedge clk);
    vectors++;
    if (done_cnt != 2) begin
      miscompares++;
      $display("[TB] FAIL b2b_done_count: got %0d, required 2", done_cnt);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_idle_busy: got %b, required 0", busy);
    end
    check_queues_empty("b2b");
  endtask

  task automatic test_timeout();
    logic [2:0] got, want;
    buf_data_ready = 1'b0;
    push_txn(12'h100, 1'b0);
    issue_start(12'h100);
    for (int k = 0; k < 72; k++) begin
      got  = {err, busy, buf_stream};
      want = {k == 69, k <= 69, 1'b0};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("[TB] FAIL timeout_cycle%0d: {err,busy,strm} got %b, required %b", k, got, want);
      end
      @(negedge clk);
    end
    buf_data_ready = 1'b1;
    check_queues_empty("timeout");
  endtask

  task automatic test_reset_mid_load();
    push_txn(12'h050, 1'b1);
    issue_start(12'h050);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    vectors++;
    if ({busy, done, err, mem_rd_en, mem_addr, wgt_write, buf_stream, col_valid, col_index} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %b, required all zero",
               {busy, done, err, mem_rd_en, mem_addr, wgt_write, buf_stream, col_valid, col_index});
    end
    @(negedge clk);
    rstn = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_col_q.delete();
    push_txn(12'h060, 1'b1);
    issue_start(12'h060);
    wait_done("midreset_restart", 40);
    @(negedge clk);
    check_queues_empty("midreset");
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) sram[i] = DW'(i * 7 + 3) ^ 16'h5A00;
    sram[12'h010] = 16'd1;
    sram[12'h011] = 16'd2;
    sram[12'h012] = 16'd3;
    sram[12'h013] = 16'd4;
    start          = 1'b0;
    base_addr      = '0;
    buf_data_ready = 1'b1;
    array_stall    = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
